board_display_scanner: RTL

- Read-side consumer of the 10x20 playfield store. Walks a 640x480@60 VGA raster, converts each pixel inside the board window into a cell address `ra` (row*10+col), and reads back the 3-bit cell type `rd`.
- Overlays the falling piece's four cells, draws a border, and drives the `hs`, `vs` and 12-bit `rgb` outputs to the VGA connector.
- Sits between the playfield store and the top-level VGA pins.

---
 rtl/board_display_scanner_if.sv | 27 ++
 rtl/board_display_scanner.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/board_display_scanner_if.sv
// Pixel-stream bundle between the board scanner, the playfield store and the VGA pins.
interface board_display_scanner_if;
  // No valid/ready: hs/vs/rgb advance one pixel per pixel tick, and rd answers
  // ra combinationally in the same cycle, so every signal is always "valid".
  logic [7:0]  ra;
  logic [2:0]  rd;
  logic [4:0]  cur_x1, cur_x2, cur_x3, cur_x4;
  logic [4:0]  cur_y1, cur_y2, cur_y3, cur_y4;
  logic [2:0]  cur_type;
  logic        show_piece;
  logic        hs;
  logic        vs;
  logic [11:0] rgb;
  logic        frame_start;

  modport master (
    output ra, hs, vs, rgb, frame_start,
    input  rd, cur_x1, cur_x2, cur_x3, cur_x4,
    input  cur_y1, cur_y2, cur_y3, cur_y4, cur_type, show_piece
  );

  modport slave (
    input  ra, hs, vs, rgb, frame_start,
    output rd, cur_x1, cur_x2, cur_x3, cur_x4,
    output cur_y1, cur_y2, cur_y3, cur_y4, cur_type, show_piece
  );
endinterface

// File: rtl/board_display_scanner.sv
// 640x480@60 raster scanner: reads the 10x20 playfield, overlays the falling piece,
// draws a border and drives VGA sync/colour with a two-tick pipeline.
module board_display_scanner #(
  parameter int          PIX_DIV    = 4,
  parameter int          X0         = 240,
  parameter int          Y0         = 80,
  parameter int          CELL_LOG2  = 4,
  parameter logic [11:0] BORDER_RGB = 12'h888
) (
  input logic                     clk,
  input logic                     rstn,
  board_display_scanner_if.master bus
);
  localparam int               DIV_W    = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(PIX_DIV - 1);
  localparam int               CELL     = 1 << CELL_LOG2;
  localparam logic [10:0]      BX0      = 11'(X0);
  localparam logic [10:0]      BX1      = 11'(X0 + 10 * CELL);
  localparam logic [10:0]      BY0      = 11'(Y0);
  localparam logic [10:0]      BY1      = 11'(Y0 + 20 * CELL);

  function automatic logic [11:0] pal(input logic [2:0] t);
    case (t)
      3'd0:    pal = 12'h000;
      3'd1:    pal = 12'hF00;
      3'd2:    pal = 12'h0F0;
      3'd3:    pal = 12'h00F;
      3'd4:    pal = 12'h0FF;
      3'd5:    pal = 12'hF0F;
      3'd6:    pal = 12'hFF0;
      default: pal = 12'hF80;
    endcase
  endfunction

  logic [DIV_W-1:0] div;
  logic             tick;
  logic [9:0]       hcnt, vcnt;
  logic             frame_tick;

  assign tick       = (div == DIV_LAST);
  assign frame_tick = tick && (hcnt == 10'd0) && (vcnt == 10'd0);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      div  <= '0;
      hcnt <= '0;
      vcnt <= '0;
    end else begin
      div <= tick ? '0 : div + 1'b1;
      if (tick) begin
        if (hcnt == 10'd799) begin
          hcnt <= '0;
          vcnt <= (vcnt == 10'd524) ? '0 : vcnt + 1'b1;
        end else begin
          hcnt <= hcnt + 1'b1;
        end
      end
    end
  end

  // Piece inputs are sampled once per frame so mid-frame moves never tear the image.
  logic [4:0] sx [4];
  logic [4:0] sy [4];
  logic [2:0] type_sh;
  logic       show_sh;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < 4; i++) begin
        sx[i] <= '0;
        sy[i] <= '0;
      end
      type_sh          <= '0;
      show_sh          <= 1'b0;
      bus.frame_start  <= 1'b0;
    end else begin
      bus.frame_start <= frame_tick;
      if (frame_tick) begin
        sx[0]   <= bus.cur_x1;
        sx[1]   <= bus.cur_x2;
        sx[2]   <= bus.cur_x3;
        sx[3]   <= bus.cur_x4;
        sy[0]   <= bus.cur_y1;
        sy[1]   <= bus.cur_y2;
        sy[2]   <= bus.cur_y3;
        sy[3]   <= bus.cur_y4;
        type_sh <= bus.cur_type;
        show_sh <= bus.show_piece;
      end
    end
  end

  logic [10:0] hx, vx;
  logic [9:0]  hoff, voff;
  logic [4:0]  col, row;
  logic [7:0]  addr;
  logic        in_board_c, border_c, visible_c, hit_c, hs_c, vs_c;

  assign hx         = {1'b0, hcnt};
  assign vx         = {1'b0, vcnt};
  assign hoff       = hcnt - 10'(X0);
  assign voff       = vcnt - 10'(Y0);
  assign col        = 5'(hoff >> CELL_LOG2);
  assign row        = 5'(voff >> CELL_LOG2);
  assign addr       = 8'(row) * 8'd10 + 8'(col);
  assign in_board_c = (hx >= BX0) && (hx < BX1) && (vx >= BY0) && (vx < BY1);
  // Written with +4 on the counter side so a window near the screen edge cannot underflow.
  assign border_c   = !in_board_c && (hx + 11'd4 >= BX0) && (hx < BX1 + 11'd4) &&
                      (vx + 11'd4 >= BY0) && (vx < BY1 + 11'd4);
  assign visible_c  = (hcnt < 10'd640) && (vcnt < 10'd480);
  assign hs_c       = !((hcnt >= 10'd656) && (hcnt <= 10'd751));
  assign vs_c       = !((vcnt >= 10'd490) && (vcnt <= 10'd491));

  // Gated by in_board so out-of-window garbage col/row can never hit an off-board shadow cell.
  always_comb begin
    hit_c = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if ((col == sx[i]) && (row == sy[i])) hit_c = 1'b1;
    end
    hit_c = hit_c && show_sh && in_board_c;
  end

  logic s1_in, s1_hit, s1_border, s1_vis, s1_hs, s1_vs;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      bus.ra    <= '0;
      s1_in     <= 1'b0;
      s1_hit    <= 1'b0;
      s1_border <= 1'b0;
      s1_vis    <= 1'b0;
      s1_hs     <= 1'b1;
      s1_vs     <= 1'b1;
    end else if (tick) begin
      if (in_board_c) bus.ra <= addr;
      s1_in     <= in_board_c;
      s1_hit    <= hit_c;
      s1_border <= border_c;
      s1_vis    <= visible_c;
      s1_hs     <= hs_c;
      s1_vs     <= vs_c;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      bus.rgb <= '0;
      bus.hs  <= 1'b1;
      bus.vs  <= 1'b1;
    end else if (tick) begin
      bus.hs <= s1_hs;
      bus.vs <= s1_vs;
      if (!s1_vis)        bus.rgb <= 12'h000;
      else if (s1_hit)    bus.rgb <= pal(type_sh);
      else if (s1_in)     bus.rgb <= pal(bus.rd);
      else if (s1_border) bus.rgb <= BORDER_RGB;
      else                bus.rgb <= 12'h000;
    end
  end
endmodule
